// File: rtl/cipher_serializer.sv
// Captures a packed cipher word on load and streams it out MSB byte first over
// a valid/ready handshake, flagging the last byte and keeping a mod-256 checksum.
module cipher_serializer #(
    parameter int unsigned p_message_length = 6
) (
    input  logic                          i_w_clk,
    input  logic                          i_w_rst_n,
    input  logic [p_message_length*8-1:0] i_w_cipher,
    input  logic                          i_w_load,
    output logic                          o_r_busy,
    output logic [7:0]                    o_r_data,
    output logic                          o_r_valid,
    input  logic                          i_w_ready,
    output logic                          o_r_last,
    output logic                          o_r_done,
    output logic [7:0]                    o_r_checksum
);

    localparam int unsigned W  = p_message_length * 8;
    localparam int unsigned CW = $clog2(p_message_length + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(p_message_length - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [7:0]    csum_q,  csum_d;

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_w_load) begin
                    shreg_d = i_w_cipher;
                    cnt_d   = '0;
                    csum_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (i_w_ready) begin
                    csum_d  = csum_q + shreg_q[W-1 -: 8];
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = shreg_q << 8;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign o_r_valid    = (state_q == S_SEND);
    assign o_r_busy     = (state_q != S_IDLE);
    assign o_r_done     = (state_q == S_DONE);
    assign o_r_last     = (state_q == S_SEND) && (cnt_q == LAST_IDX);
    assign o_r_data     = shreg_q[W-1 -: 8];
    assign o_r_checksum = csum_q;

endmodule
